// File: rtl/fpmult_rr_scheduler_if.sv
// Purpose: bundles the requester, shared-multiplier and response signals of the FP32 mult scheduler.
// Latency: none (wires only).
// Backpressure: requester side uses req_valid/req_ready; the response and multiplier sides have none.
interface fpmult_rr_scheduler_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
);
    // Requester side
    logic [NREQ-1:0]      req_valid;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    // Shared multiplier side
    logic [31:0]          mul_a;
    logic [31:0]          mul_b;
    logic [31:0]          mul_result;
    logic [4:0]           mul_flags;
    // Response side
    logic [NREQ-1:0]      rsp_valid;
    logic [31:0]          rsp_result;
    logic [4:0]           rsp_flags;
    logic [IDW-1:0]       rsp_id;
    logic                 busy;

    // Scheduler view
    modport slave (
        input  req_valid, req_a, req_b, mul_result, mul_flags,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_result, rsp_flags, rsp_id, busy
    );

    // Requesters + multiplier view
    modport master (
        output req_valid, req_a, req_b, mul_result, mul_flags,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_result, rsp_flags, rsp_id, busy
    );
endinterface

// File: rtl/fpmult_rr_scheduler.sv
// Purpose: round-robin sharing of one fixed-latency FP32 multiplier among NREQ requesters (FPM_SCHED_PRIO0_EN: req0 absolute priority).
// Latency: handshake edge to rsp_valid strobe is MUL_LAT+1 cycles; grant is combinational.
// Backpressure: one grant per cycle via req_ready; responses are strobed with no backpressure.
module fpmult_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 4,
    parameter int IDW     = 3
) (
    input  logic               clk,
    input  logic               rst,
    fpmult_rr_scheduler_if.slave bus
);

`ifdef FPM_SCHED_PRIO0_EN
    // Pointer only rotates among requesters 1..NREQ-1; req0 bypasses it.
    localparam logic [IDW-1:0] PTR_RST = IDW'(1);
`else
    localparam logic [IDW-1:0] PTR_RST = '0;
`endif

    logic [IDW-1:0]         r_ptr;
    logic [31:0]            r_mul_a;
    logic [31:0]            r_mul_b;
    logic [MUL_LAT:0]       r_tag_vld;
    logic [IDW-1:0]         r_tag_id [MUL_LAT+1];
    logic [NREQ-1:0]        r_rsp_valid;
    logic [31:0]            r_rsp_result;
    logic [4:0]             r_rsp_flags;
    logic [IDW-1:0]         r_rsp_id;

    logic [2**IDW-1:0]      w_vld_pad;
    logic [IDW:0]           w_idx;
    logic                   w_hs;
    logic [IDW-1:0]         w_gnt_id;
    logic [NREQ-1:0]        w_grant;
    logic [IDW-1:0]         w_ptr_nxt;
    logic [31:0]            w_op_a;
    logic [31:0]            w_op_b;

    // Pad the valid vector so an IDW-bit id can index it directly.
    assign w_vld_pad = (2**IDW)'(bus.req_valid);

    // Winner search: first valid requester at or after the pointer, wrapping modulo the ring size.
    always_comb begin
        w_hs     = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
`ifdef FPM_SCHED_PRIO0_EN
        if (bus.req_valid[0]) begin
            w_hs     = 1'b1;
            w_gnt_id = '0;
        end else begin
            for (int off = 0; off < NREQ - 1; off++) begin
                w_idx = {1'b0, r_ptr} + (IDW+1)'(off);
                if (w_idx >= (IDW+1)'(NREQ))
                    w_idx = w_idx - (IDW+1)'(NREQ - 1);
                if (!w_hs && w_vld_pad[w_idx[IDW-1:0]]) begin
                    w_hs     = 1'b1;
                    w_gnt_id = w_idx[IDW-1:0];
                end
            end
        end
`else
        for (int off = 0; off < NREQ; off++) begin
            w_idx = {1'b0, r_ptr} + (IDW+1)'(off);
            if (w_idx >= (IDW+1)'(NREQ))
                w_idx = w_idx - (IDW+1)'(NREQ);
            if (!w_hs && w_vld_pad[w_idx[IDW-1:0]]) begin
                w_hs     = 1'b1;
                w_gnt_id = w_idx[IDW-1:0];
            end
        end
`endif
    end

    // One-hot grant, next pointer and the winner's operand mux.
    always_comb begin
        w_grant   = w_hs ? (NREQ'(1) << w_gnt_id) : '0;
        w_ptr_nxt = r_ptr;
`ifdef FPM_SCHED_PRIO0_EN
        if (w_hs && (w_gnt_id != '0))
            w_ptr_nxt = (w_gnt_id == IDW'(NREQ - 1)) ? IDW'(1) : w_gnt_id + IDW'(1);
`else
        if (w_hs)
            w_ptr_nxt = (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + IDW'(1);
`endif
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_id == IDW'(i)) begin
                w_op_a = bus.req_a[32*i +: 32];
                w_op_b = bus.req_b[32*i +: 32];
            end
        end
    end

    // Issue: advance the pointer and launch operands only on a handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr   <= PTR_RST;
            r_mul_a <= '0;
            r_mul_b <= '0;
        end else if (w_hs) begin
            r_ptr   <= w_ptr_nxt;
            r_mul_a <= w_op_a;
            r_mul_b <= w_op_b;
        end
    end

    // Tag pipe: free-running shift aligned with the multiplier; reset drops all in-flight ops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_vld <= '0;
            for (int s = 0; s <= MUL_LAT; s++)
                r_tag_id[s] <= '0;
        end else begin
            r_tag_vld   <= {r_tag_vld[MUL_LAT-1:0], w_hs};
            r_tag_id[0] <= w_gnt_id;
            for (int s = 1; s <= MUL_LAT; s++)
                r_tag_id[s] <= r_tag_id[s-1];
        end
    end

    // Response: capture result when the last tag stage is valid; strobe lasts one cycle, data holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_id     <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (r_tag_vld[MUL_LAT]) begin
                r_rsp_valid  <= NREQ'(1) << r_tag_id[MUL_LAT];
                r_rsp_result <= bus.mul_result;
                r_rsp_flags  <= bus.mul_flags;
                r_rsp_id     <= r_tag_id[MUL_LAT];
            end
        end
    end

    assign bus.req_ready  = w_grant;
    assign bus.mul_a      = r_mul_a;
    assign bus.mul_b      = r_mul_b;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_flags  = r_rsp_flags;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.busy       = |r_tag_vld;

endmodule

// File: tb/tb_fpmult_rr_scheduler.sv
// Purpose: directed + random check of fpmult_rr_scheduler against a queue-based scoreboard and a behavioural FP32 multiplier.
// Latency: expects each response MUL_LAT+1 cycles after its handshake edge.
// Backpressure: none on responses; grants are checked every cycle against a ring-order model.
module tb_fpmult_rr_scheduler;
    localparam int NREQ    = 4;
    localparam int MUL_LAT = 4;
    localparam int IDW     = 3;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    fpmult_rr_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    fpmult_rr_scheduler #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truncating FP32 multiply for normal operands; returns {flags, result}.
    // flags = {invalid, div_by_zero, overflow, underflow, inexact}
    function automatic logic [36:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        logic [22:0] m;
        logic        lost;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
            return {5'b00000, s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        if (p[47]) begin
            m    = p[46:24];
            lost = |p[23:0];
            e    = int'(a[30:23]) + int'(b[30:23]) - 126;
        end else begin
            m    = p[45:23];
            lost = |p[22:0];
            e    = int'(a[30:23]) + int'(b[30:23]) - 127;
        end
        if (e >= 255) return {5'b00101, s, 8'hFF, 23'd0};
        if (e <= 0)   return {5'b00011, s, 31'd0};
        return {4'b0000, lost, s, e[7:0], m};
    endfunction

    // Fixed-latency multiplier stand-in: MUL_LAT register stages after mul_a/mul_b.
    logic [36:0] mpipe [MUL_LAT];
    always @(posedge clk) begin
        mpipe[0] <= fmul(bus.mul_a, bus.mul_b);
        for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign bus.mul_result = mpipe[MUL_LAT-1][31:0];
    assign bus.mul_flags  = mpipe[MUL_LAT-1][36:32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

`ifdef FPM_SCHED_PRIO0_EN
    localparam int PTR_RST = 1;
    function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
        if (v[0]) return 0;
        for (int off = 0; off < NREQ - 1; off++)
            if (v[1 + ((p - 1 + off) % (NREQ - 1))]) return 1 + ((p - 1 + off) % (NREQ - 1));
        return -1;
    endfunction
    function automatic int model_ptr(input int g, input int p);
        return (g == 0) ? p : (g % (NREQ - 1)) + 1;
    endfunction
`else
    localparam int PTR_RST = 0;
    function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
        for (int off = 0; off < NREQ; off++)
            if (v[(p + off) % NREQ]) return (p + off) % NREQ;
        return -1;
    endfunction
    function automatic int model_ptr(input int g, input int p);
        return (g + 1) % NREQ;
    endfunction
`endif

    // Scoreboard: every handshake is expected back, in issue order, a fixed number of samples later.
    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        int          due;
    } ent_t;

    ent_t        q[$];
    ent_t        e;
    int          ncyc;
    int          mptr;
    int          g;
    logic [36:0] r;
    logic [31:0] last_res;
    logic [4:0]  last_flags;
    logic [IDW-1:0] last_id;

    initial begin
        ncyc = 0; mptr = PTR_RST; last_res = '0; last_flags = '0; last_id = '0;
    end

    // Monitor samples on the falling edge, between input changes and active edges.
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            mptr       = PTR_RST;
            last_res   = '0;
            last_flags = '0;
            last_id    = '0;
        end else begin
            if (q.size() > 0 && q[0].due == ncyc) begin
                e = q.pop_front();
                r = fmul(e.a, e.b);
                chk("rsp_valid", 64'(bus.rsp_valid), 64'(NREQ'(1) << e.id));
                chk("rsp_result", 64'(bus.rsp_result), 64'(r[31:0]));
                chk("rsp_flags", 64'(bus.rsp_flags), 64'(r[36:32]));
                chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                last_res   = r[31:0];
                last_flags = r[36:32];
                last_id    = IDW'(e.id);
            end else begin
                chk("rsp_valid_idle", 64'(bus.rsp_valid), 64'd0);
                chk("rsp_hold", {24'd0, bus.rsp_flags, bus.rsp_id, bus.rsp_result},
                    {24'd0, last_flags, last_id, last_res});
            end
            chk("busy", 64'(bus.busy), 64'(q.size() != 0));
            g = model_grant(bus.req_valid, mptr);
            chk("req_ready", 64'(bus.req_ready), (g < 0) ? 64'd0 : 64'(NREQ'(1) << g));
            if (g >= 0) begin
                e.id  = g;
                e.a   = bus.req_a[32*g +: 32];
                e.b   = bus.req_b[32*g +: 32];
                e.due = ncyc + MUL_LAT + 2;
                q.push_back(e);
                mptr = model_ptr(g, mptr);
            end
        end
        ncyc++;
    end

    function automatic logic [31:0] rnd_fp();
        logic [7:0] ex;
        ex = 8'(64 + $urandom_range(0, 126));
        return {1'($urandom), ex, 23'($urandom)};
    endfunction

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
    endtask

    task automatic rnd_ops();
        for (int i = 0; i < NREQ; i++) set_op(i, rnd_fp(), rnd_fp());
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b0;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        #3;
        chk("rst_mul_a", 64'(bus.mul_a), 64'd0);
        chk("rst_mul_b", 64'(bus.mul_b), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
        chk("rst_rsp_flags", 64'(bus.rsp_flags), 64'd0);
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        step();
        rst = 1'b1;
        #1;

`ifdef FPM_SCHED_PRIO0_EN
        // req0 dominates while valid, then the others rotate from 1
        rnd_ops();
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1 chk("prio0_grant", 64'(bus.req_ready), 64'd1);
            step();
        end
        bus.req_valid = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            #1 chk("prio_rr_grant", 64'(bus.req_ready), 64'(4'b0010 << i));
            step();
        end
`else
        // all four valid: grants rotate 0,1,2,3,0,1,2,3
        rnd_ops();
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1 chk("rr_grant", 64'(bus.req_ready), 64'(4'b0001 << (i % 4)));
            step();
        end
`endif
        bus.req_valid = '0;
        repeat (8) step();

        // single op 2.0*3.0 from req0
        set_op(0, 32'h40000000, 32'h40400000);
        bus.req_valid = 4'b0001;
        #1 chk("single_grant", 64'(bus.req_ready), 64'd1);
        step();
        bus.req_valid = '0;
        repeat (MUL_LAT) step();
        chk("single_early", 64'(bus.rsp_valid), 64'd0);
        step();
        chk("single_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("single_rsp_result", 64'(bus.rsp_result), 64'h40C00000);
        chk("single_rsp_id", 64'(bus.rsp_id), 64'd0);
        step();
        chk("single_strobe_end", 64'(bus.rsp_valid), 64'd0);
        chk("single_hold", 64'(bus.rsp_result), 64'h40C00000);
        repeat (2) step();

        // routing: req1 1.5*1.5 then req3 -1*4 on the next cycle
        set_op(1, 32'h3FC00000, 32'h3FC00000);
        set_op(3, 32'hBF800000, 32'h40800000);
        bus.req_valid = 4'b0010;
        step();
        bus.req_valid = 4'b1000;
        step();
        bus.req_valid = '0;
        repeat (MUL_LAT - 1) step();
        step();
        chk("route1_valid", 64'(bus.rsp_valid), 64'b0010);
        chk("route1_result", 64'(bus.rsp_result), 64'h40100000);
        step();
        chk("route3_valid", 64'(bus.rsp_valid), 64'b1000);
        chk("route3_result", 64'(bus.rsp_result), 64'hC0800000);
        chk("route3_id", 64'(bus.rsp_id), 64'd3);
        chk("route_busy_fall", 64'(bus.busy), 64'd0);
        repeat (2) step();

        // sparse: req2 valid on odd cycles only
        for (int i = 0; i < 10; i++) begin
            set_op(2, rnd_fp(), rnd_fp());
            bus.req_valid = (i % 2 == 1) ? 4'b0100 : 4'b0000;
            step();
        end
        bus.req_valid = '0;
        repeat (MUL_LAT + 2) step();
        chk("sparse_drained", 64'(bus.busy), 64'd0);

        // reset with three ops in flight
        rnd_ops();
        bus.req_valid = 4'b0111;
        repeat (3) step();
        rst = 1'b0;
        bus.req_valid = '0;
        #1;
        chk("mid_rst_mul_a", 64'(bus.mul_a), 64'd0);
        chk("mid_rst_mul_b", 64'(bus.mul_b), 64'd0);
        chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mid_rst_rsp_result", 64'(bus.rsp_result), 64'd0);
        chk("mid_rst_rsp_flags", 64'(bus.rsp_flags), 64'd0);
        chk("mid_rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        repeat (2) step();
        rst = 1'b1;
        bus.req_valid = 4'b1111;
        #1 chk("post_rst_grant", 64'(bus.req_ready), 64'd1);
        step();
        bus.req_valid = '0;
        repeat (MUL_LAT + 4) step();

        // random traffic against the scoreboard
        repeat (400) begin
            rnd_ops();
            bus.req_valid = NREQ'($urandom);
            step();
        end
        bus.req_valid = '0;
        repeat (MUL_LAT + 4) step();
        chk("final_drained", 64'(bus.busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
